// File: rtl/axi4_lite_read_arbiter.sv
// Round-robin arbiter sharing one AXI4-Lite read channel (AR + R) among NUM_REQ requesters.
// At most one read is in flight. The winner's address is latched, and the single R beat is routed back to that requester.
//
// state   | meaning
// --------+------------------------------------------------------------
// IDLE    | no read in flight; arbitrate and accept the winner at once
// ADDR    | arvalid held with latched araddr/arprot until arready
// DATA    | R channel connected to the granted requester until handshake
module axi4_lite_read_arbiter #(
  parameter int NUM_REQ       = 2,
  parameter int ADDRESS_WIDTH = 32,
  parameter int DATA_WIDTH    = 32,
  localparam int GW           = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic                             aclk,
  input  logic                             aresetn,
  input  logic [NUM_REQ*ADDRESS_WIDTH-1:0] req_araddr,
  input  logic [NUM_REQ*3-1:0]             req_arprot,
  input  logic [NUM_REQ-1:0]               req_arvalid,
  output logic [NUM_REQ-1:0]               req_arready,
  output logic [DATA_WIDTH-1:0]            req_rdata,
  output logic [1:0]                       req_rresp,
  output logic [NUM_REQ-1:0]               req_rvalid,
  input  logic [NUM_REQ-1:0]               req_rready,
  output logic [ADDRESS_WIDTH-1:0]         araddr,
  output logic [2:0]                       arprot,
  output logic                             arvalid,
  input  logic                             arready,
  input  logic [DATA_WIDTH-1:0]            rdata,
  input  logic [1:0]                       rresp,
  input  logic                             rvalid,
  output logic                             rready,
  output logic [GW-1:0]                    grant_id,
  output logic                             busy
);

  typedef enum logic [1:0] {ST_IDLE, ST_ADDR, ST_DATA} state_t;

  state_t                   r_state;
  state_t                   w_state_nxt;
  logic [GW-1:0]            r_last_grant;
  logic [GW-1:0]            r_grant_id;
  logic [ADDRESS_WIDTH-1:0] r_araddr;
  logic [2:0]               r_arprot;
  logic                     r_arvalid;

  logic [ADDRESS_WIDTH-1:0] w_addr_arr [NUM_REQ];
  logic [2:0]               w_prot_arr [NUM_REQ];
  logic                     w_found;
  logic [GW-1:0]            w_winner;
  logic [GW:0]              w_sum;

  for (genvar i = 0; i < NUM_REQ; i++) begin : g_slice
    assign w_addr_arr[i] = req_araddr[i*ADDRESS_WIDTH +: ADDRESS_WIDTH];
    assign w_prot_arr[i] = req_arprot[i*3 +: 3];
  end

  // Search starts one past the last grant and wraps, so the last winner has the lowest priority.
  always_comb begin
    w_found  = 1'b0;
    w_winner = '0;
    w_sum    = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      w_sum = {1'b0, r_last_grant} + (GW+1)'(k);
      if (w_sum >= (GW+1)'(NUM_REQ))
        w_sum = w_sum - (GW+1)'(NUM_REQ);
      if (!w_found && req_arvalid[GW'(w_sum)]) begin
        w_found  = 1'b1;
        w_winner = GW'(w_sum);
      end
    end
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) r_state <= ST_IDLE;
    else          r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    req_arready = '0;
    req_rvalid  = '0;
    rready      = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_found) begin
          req_arready[w_winner] = 1'b1;
          w_state_nxt           = ST_ADDR;
        end
      end
      ST_ADDR: begin
        if (arready) w_state_nxt = ST_DATA;
      end
      ST_DATA: begin
        rready                 = req_rready[r_grant_id];
        req_rvalid[r_grant_id] = rvalid;
        if (rvalid && req_rready[r_grant_id]) w_state_nxt = ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      r_araddr     <= '0;
      r_arprot     <= '0;
      r_arvalid    <= 1'b0;
      r_grant_id   <= '0;
      r_last_grant <= GW'(NUM_REQ - 1);
    end else begin
      if (r_state == ST_IDLE && w_found) begin
        r_araddr   <= w_addr_arr[w_winner];
        r_arprot   <= w_prot_arr[w_winner];
        r_grant_id <= w_winner;
        r_arvalid  <= 1'b1;
      end
      if (r_state == ST_ADDR && arready)
        r_arvalid <= 1'b0;
      if (r_state == ST_DATA && rvalid && req_rready[r_grant_id])
        r_last_grant <= r_grant_id;
    end
  end

  assign araddr    = r_araddr;
  assign arprot    = r_arprot;
  assign arvalid   = r_arvalid;
  assign grant_id  = r_grant_id;
  assign busy      = (r_state != ST_IDLE);
  assign req_rdata = rdata;
  assign req_rresp = rresp;

endmodule
